// File: rtl/sprite_shifter_bank_if.sv
// Load bus from sprite fetch into the sprite output unit bank.
interface sprite_shifter_bank_if;
  logic       load_en;
  logic [2:0] load_idx;
  logic [7:0] load_pat_lo;
  logic [7:0] load_pat_hi;
  logic [7:0] load_attr;
  logic [7:0] load_x;

  modport master (output load_en, load_idx, load_pat_lo, load_pat_hi, load_attr, load_x);
  modport slave  (input  load_en, load_idx, load_pat_lo, load_pat_hi, load_attr, load_x);
endinterface

// File: rtl/sprite_shifter_bank.sv
// Eight sprite output units: X down-counter, two pattern shifters and attributes
// per unit, emitting one pixel/priority pair per unit per visible dot.
module sprite_shifter_bank #(
  parameter int XCNT_W = 8,
  parameter int PAL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pixel_en,
  input  logic                    visible,
  input  logic                    clear_all,
  sprite_shifter_bank_if.slave    lb,
  output logic [PAL_W+1:0]        sprite_pixel_0,
  output logic [PAL_W+1:0]        sprite_pixel_1,
  output logic [PAL_W+1:0]        sprite_pixel_2,
  output logic [PAL_W+1:0]        sprite_pixel_3,
  output logic [PAL_W+1:0]        sprite_pixel_4,
  output logic [PAL_W+1:0]        sprite_pixel_5,
  output logic [PAL_W+1:0]        sprite_pixel_6,
  output logic [PAL_W+1:0]        sprite_pixel_7,
  output logic [7:0]              sprite_priority_buff
);

  logic [7:0]        pat_lo [8];
  logic [7:0]        pat_hi [8];
  logic [PAL_W-1:0]  pal    [8];
  logic              prio   [8];
  logic [XCNT_W-1:0] xcnt   [8];
  logic [PAL_W+1:0]  pix    [8];

  logic unused_attr;
  assign unused_attr = ^{lb.load_attr[7], lb.load_attr[4:PAL_W]};

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  // Load beats clear_all for its own unit only; every other unit still clears or advances.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (rst) begin
        pat_lo[i] <= '0;
        pat_hi[i] <= '0;
        pal[i]    <= '0;
        prio[i]   <= 1'b1;
        xcnt[i]   <= '0;
      end else if (lb.load_en && lb.load_idx == 3'(i)) begin
        pat_lo[i] <= lb.load_attr[6] ? rev8(lb.load_pat_lo) : lb.load_pat_lo;
        pat_hi[i] <= lb.load_attr[6] ? rev8(lb.load_pat_hi) : lb.load_pat_hi;
        pal[i]    <= lb.load_attr[PAL_W-1:0];
        prio[i]   <= lb.load_attr[5];
        xcnt[i]   <= XCNT_W'(lb.load_x);
      end else if (clear_all) begin
        pat_lo[i] <= '0;
        pat_hi[i] <= '0;
        pal[i]    <= '0;
        prio[i]   <= 1'b1;
        xcnt[i]   <= '0;
      end else if (pixel_en && visible) begin
        if (xcnt[i] != '0) begin
          xcnt[i] <= xcnt[i] - 1'b1;
        end else begin
          pat_lo[i] <= {pat_lo[i][6:0], 1'b0};
          pat_hi[i] <= {pat_hi[i][6:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    sprite_priority_buff = '1;
    for (int unsigned i = 0; i < 8; i++) begin
      pix[i] = '0;
      if (xcnt[i] == '0) begin
        pix[i]                  = {pal[i], pat_hi[i][7], pat_lo[i][7]};
        sprite_priority_buff[i] = prio[i];
      end
    end
  end

  assign sprite_pixel_0 = pix[0];
  assign sprite_pixel_1 = pix[1];
  assign sprite_pixel_2 = pix[2];
  assign sprite_pixel_3 = pix[3];
  assign sprite_pixel_4 = pix[4];
  assign sprite_pixel_5 = pix[5];
  assign sprite_pixel_6 = pix[6];
  assign sprite_pixel_7 = pix[7];

endmodule

// File: tb/tb_sprite_shifter_bank.sv
// Scoreboard bench for sprite_shifter_bank: a dot-count reference model pushes
// expected outputs per cycle; a negedge monitor pops and compares.
module tb_sprite_shifter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pixel_en, visible, clear_all;
  sprite_shifter_bank_if lb ();
  logic [3:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic [7:0] prio_buff;

  sprite_shifter_bank #(.XCNT_W(8), .PAL_W(2)) dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .visible(visible), .clear_all(clear_all),
    .lb(lb.slave),
    .sprite_pixel_0(p0), .sprite_pixel_1(p1), .sprite_pixel_2(p2), .sprite_pixel_3(p3),
    .sprite_pixel_4(p4), .sprite_pixel_5(p5), .sprite_pixel_6(p6), .sprite_pixel_7(p7),
    .sprite_priority_buff(prio_buff)
  );

  // Reference model: a unit remembers its load and counts visible strobes since then.
  bit         m_valid [8];
  int         m_x     [8];
  int         m_s     [8];
  logic [7:0] m_lo    [8];
  logic [7:0] m_hi    [8];
  bit         m_flip  [8];
  logic [1:0] m_pal   [8];
  bit         m_prio  [8];
  bit         have_state = 0;

  typedef struct {
    logic [31:0] pix;
    logic [7:0]  prio;
    string       tag;
  } exp_t;
  exp_t q[$];
  string tag = "reset";
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [3:0] model_pix(int i);
    int k, b;
    if (!m_valid[i] || m_s[i] < m_x[i]) return 4'h0;
    k = m_s[i] - m_x[i];
    if (k >= 8) return {m_pal[i], 2'b00};
    b = m_flip[i] ? k : 7 - k;
    return {m_pal[i], m_hi[i][b], m_lo[i][b]};
  endfunction

  function automatic bit model_prio(int i);
    if (!m_valid[i] || m_s[i] < m_x[i]) return 1'b1;
    return m_prio[i];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 8; i++) begin
      if (rst) m_valid[i] = 0;
      else if (lb.load_en && int'(lb.load_idx) == i) begin
        m_valid[i] = 1;
        m_x[i]     = int'(lb.load_x);
        m_s[i]     = 0;
        m_lo[i]    = lb.load_pat_lo;
        m_hi[i]    = lb.load_pat_hi;
        m_flip[i]  = lb.load_attr[6];
        m_pal[i]   = lb.load_attr[1:0];
        m_prio[i]  = lb.load_attr[5];
      end else if (clear_all) m_valid[i] = 0;
      else if (pixel_en && visible && m_s[i] < 1000) m_s[i]++;
    end
    have_state = 1;
  endtask

  task automatic tick();
    exp_t e;
    if (have_state) begin
      for (int i = 0; i < 8; i++) begin
        e.pix[4*i +: 4] = model_pix(i);
        e.prio[i]       = model_prio(i);
      end
      e.tag = tag;
      q.push_back(e);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {p7, p6, p5, p4, p3, p2, p1, p0};
      n_checks++;
      if (got === e.pix) n_pass++;
      else $display("FAIL pixels[%s] got=%h exp=%h", e.tag, got, e.pix);
      n_checks++;
      if (prio_buff === e.prio) n_pass++;
      else $display("FAIL priority[%s] got=%h exp=%h", e.tag, prio_buff, e.prio);
    end
  end

  task automatic idle_inputs();
    rst = 0; pixel_en = 0; visible = 0; clear_all = 0;
    lb.load_en = 0; lb.load_idx = '0; lb.load_pat_lo = '0; lb.load_pat_hi = '0;
    lb.load_attr = '0; lb.load_x = '0;
  endtask

  task automatic load(input int idx, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [7:0] attr, input logic [7:0] x);
    lb.load_en = 1; lb.load_idx = 3'(idx); lb.load_pat_lo = lo; lb.load_pat_hi = hi;
    lb.load_attr = attr; lb.load_x = x;
    tick();
    lb.load_en = 0;
  endtask

  task automatic strobes(input int n, input int gap);
    for (int s = 0; s < n; s++) begin
      pixel_en = 1; visible = 1;
      tick();
      pixel_en = 0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic clear_bank();
    clear_all = 1; tick(); clear_all = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
    tick();

    tag = "basic";
    load(0, 8'h81, 8'h00, 8'h02, 8'd3);
    strobes(14, 0);

    tag = "hflip";
    clear_bank();
    load(5, 8'h01, 8'h01, 8'h43, 8'd0);
    strobes(10, 0);

    tag = "stall";
    clear_bank();
    load(0, 8'h81, 8'h00, 8'h02, 8'd3);
    strobes(13, 20);

    tag = "hold_no_visible";
    load(3, 8'hF0, 8'h0F, 8'h21, 8'd1);
    pixel_en = 1; visible = 0; tick(); tick(); pixel_en = 0;
    strobes(4, 0);

    tag = "clear_and_load";
    load(4, 8'hFF, 8'hFF, 8'h01, 8'd0);
    clear_all = 1;
    load(2, 8'hC3, 8'h5A, 8'h23, 8'd0);
    clear_all = 0;
    strobes(9, 0);

    tag = "load_mid_shift";
    clear_bank();
    load(0, 8'hAA, 8'h55, 8'h01, 8'd1);
    load(1, 8'hFF, 8'h00, 8'h62, 8'd0);
    strobes(3, 0);
    pixel_en = 1; visible = 1;
    load(1, 8'h80, 8'h80, 8'h03, 8'd0);
    pixel_en = 0;
    strobes(9, 0);

    tag = "reset_mid_line";
    clear_bank();
    load(0, 8'hFF, 8'hFF, 8'h03, 8'd0);
    load(3, 8'hFF, 8'h00, 8'h21, 8'd0);
    load(7, 8'h00, 8'hFF, 8'h02, 8'd2);
    strobes(5, 0);
    rst = 1; pixel_en = 1; visible = 1; tick();
    rst = 0; pixel_en = 0;
    tick(); tick();

    tag = "random";
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      clear_all   = ($urandom_range(0, 59) == 0);
      pixel_en    = ($urandom_range(0, 1) == 1);
      visible     = ($urandom_range(0, 9) != 0);
      lb.load_en  = ($urandom_range(0, 7) == 0);
      lb.load_idx = 3'($urandom_range(0, 7));
      lb.load_pat_lo = 8'($urandom);
      lb.load_pat_hi = 8'($urandom);
      lb.load_attr   = 8'($urandom);
      lb.load_x      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      tick();
    end
    idle_inputs();
    tick();

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
